// File: rtl/serial_operand_serializer_msb_first.sv
`default_nettype none
// ============================================================================
// Module   : serial_operand_serializer_msb_first
// Brief    : Shifts an accepted (a, b) operand pair out MSB first on two
//            lock-step serial lines, preceded by a one-cycle comparator clear.
// Revision : 1.0 - initial release
// ============================================================================
module serial_operand_serializer_msb_first #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             cmp_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_last
);

  localparam int               CNT_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmp_clear_q, cmp_clear_d;
  logic             last_beat;
  logic             accept;

  always_comb begin
    last_beat   = (state_q == SHIFT) && (cnt_q == '0);
    // A new pair may enter while the final bit is being consumed.
    in_ready    = (state_q == IDLE) || (last_beat && out_ready);
    accept      = in_valid && in_ready;

    state_d     = state_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE:  state_d = IDLE;
      CLEAR: state_d = SHIFT;
      SHIFT: begin
        if (out_ready) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
          end else begin
            sh_a_d = sh_a_q << 1;
            sh_b_d = sh_b_q << 1;
            cnt_d  = cnt_q - C_CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d = CLEAR;
      sh_a_d  = in_a;
      sh_b_d  = in_b;
      cnt_d   = C_CNT_LOAD;
    end

    cmp_clear_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      cnt_q       <= '0;
      cmp_clear_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      cnt_q       <= cnt_d;
      cmp_clear_q <= cmp_clear_d;
    end
  end

  // Serial lines are gated so they read zero whenever no bit is offered.
  assign cmp_clear = cmp_clear_q;
  assign out_valid = (state_q == SHIFT);
  assign out_a     = out_valid && sh_a_q[WIDTH-1];
  assign out_b     = out_valid && sh_b_q[WIDTH-1];
  assign out_last  = last_beat;

endmodule
`default_nettype wire

// File: tb/tb_serial_operand_serializer_msb_first.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_operand_serializer_msb_first
// Brief    : Scoreboard bench for the MSB-first operand serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_operand_serializer_msb_first;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, cmp_clear, out_valid, out_ready;
  logic         out_a, out_b, out_last;
  logic [W-1:0] in_a, in_b;

  logic         in_valid1, in_ready1, cmp_clear1, out_valid1, out_ready1;
  logic         out_a1, out_b1, out_last1;
  logic [0:0]   in_a1, in_b1;

  serial_operand_serializer_msb_first #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .cmp_clear(cmp_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_last(out_last)
  );

  serial_operand_serializer_msb_first #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .cmp_clear(cmp_clear1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_a(out_a1), .out_b(out_b1), .out_last(out_last1)
  );

  typedef struct packed {
    logic a;
    logic b;
    logic last;
  } beat_t;

  beat_t beat_q[$];
  int    rel_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beats are queued at each handshake and retired as the DUT emits.
  logic  hs_prev  = 1'b0;
  logic  rst_prev = 1'b0;
  logic  exp_valid, exp_ready;
  int    hist  = 0;
  int    beats = 0;
  beat_t bt;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      beat_q.delete();
      rel_q.delete();
      hs_prev  = 1'b0;
      rst_prev = 1'b1;
    end else begin
      if (rst_prev) begin
        check_val("rst_out_a", out_a, 0);
        check_val("rst_out_b", out_b, 0);
        check_val("rst_out_last", out_last, 0);
      end
      exp_valid = (beat_q.size() != 0) && !hs_prev;
      exp_ready = (beat_q.size() == 0) || (exp_valid && beat_q[0].last && out_ready);
      check_val("cmp_clear", cmp_clear, hs_prev);
      check_val("out_valid", out_valid, exp_valid);
      check_val("in_ready", in_ready, exp_ready);
      if (hs_prev) begin
        hist  = 0;
        beats = 0;
      end
      // Downstream comparator model, fed from the DUT's own serial lines.
      if (out_valid && out_ready) begin
        beats++;
        if (hist == 0 && out_a != out_b) hist = out_a ? 2 : 1;
      end
      if (exp_valid && out_ready) begin
        bt = beat_q.pop_front();
        check_val("out_a", out_a, bt.a);
        check_val("out_b", out_b, bt.b);
        check_val("out_last", out_last, bt.last);
        if (bt.last) begin
          check_val("beat_count", beats, W);
          check_val("cmp_rel", hist, rel_q.pop_front());
        end
      end
      hs_prev = in_valid && exp_ready;
      if (hs_prev) begin
        for (int i = W - 1; i >= 0; i--) beat_q.push_back('{a: in_a[i], b: in_b[i], last: (i == 0)});
        rel_q.push_back((in_a < in_b) ? 1 : ((in_a > in_b) ? 2 : 0));
      end
      rst_prev = 1'b0;
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) check_val("hs_timeout", n, 0);
    @(posedge clk);
    if (!keep) begin
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(8'h5A, 8'h5C, 1'b0);
    idle(12);

    send(8'hFF, 8'h00, 1'b1);
    send(8'h00, 8'hFF, 1'b0);
    idle(12);

    send(8'hA5, 8'hA5, 1'b0);
    repeat (5) @(negedge clk);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    idle(10);

    send(8'hC3, 8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h01, 8'h02, 1'b0);
    idle(12);

    send(8'h96, 8'h69, 1'b0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      in_a = W'($urandom);
      in_b = W'($urandom);
    end
    idle(4);
    check_val("drain_beats", beat_q.size(), 0);
    check_val("drain_words", rel_q.size(), 0);

    // Single-bit instance: clear, then one beat that is also the last.
    @(negedge clk);
    in_valid1 = 1'b1; in_a1 = 1'b1; in_b1 = 1'b0;
    #2;
    check_val("w1_in_ready_idle", in_ready1, 1);
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
    @(negedge clk);
    #2;
    check_val("w1_cmp_clear", cmp_clear1, 1);
    check_val("w1_valid_in_clear", out_valid1, 0);
    check_val("w1_in_ready_clear", in_ready1, 0);
    @(negedge clk);
    #2;
    check_val("w1_out_valid", out_valid1, 1);
    check_val("w1_out_a", out_a1, 1);
    check_val("w1_out_b", out_b1, 0);
    check_val("w1_out_last", out_last1, 1);
    check_val("w1_in_ready_last", in_ready1, 1);
    check_val("w1_clear_off", cmp_clear1, 0);
    @(negedge clk);
    #2;
    check_val("w1_idle_valid", out_valid1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
